// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions for the 16-bit processor.
package cpu_pkg;

    // Instruction memory is word addressed.
    localparam int unsigned ADDR_WIDTH = 10;

    typedef logic [ADDR_WIDTH-1:0] instr_addr_t;

    // Address loaded while reset is asserted.
    localparam instr_addr_t RESET_ADDR = 10'h000;

    // Step between sequential fetches.
    localparam instr_addr_t INCREMENT = 10'd1;

endpackage

// File: rtl/pc_adder.sv
// Sequential-fetch incrementer. It is purely combinational and wraps modulo
// 2^ADDR_WIDTH, so 10'h3FF rolls over to 10'h000. There is no carry-out.
module pc_adder
    import cpu_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] in,
    output logic [ADDR_WIDTH-1:0] out
);

    // Next sequential address, truncated to the address width.
    always_comb begin
        out = in + INCREMENT;
    end

endmodule

// File: rtl/program_counter.sv
// Instruction-fetch program counter. Holds the current fetch address and on
// every rising edge either loads a branch target, holds on stall, or advances
// to the next sequential address supplied by an external pc_adder. The output
// is a pure register with no combinational path from any input.
module program_counter
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] adder_input,
    input  logic [ADDR_WIDTH-1:0] br_address,
    output logic [ADDR_WIDTH-1:0] instr_address
);

    instr_addr_t pc_q;

    // PC register: async reset first so undefined branch/stall during reset
    // cannot leak into the output; branch outranks stall so a taken branch
    // still redirects fetch while the pipeline is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else if (branch) begin
            pc_q <= br_address;
        end else if (!stall) begin
            pc_q <= adder_input;
        end
    end

    assign instr_address = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Closed-loop bench: program_counter with pc_adder wired beside it, as at the
// fetch-stage level. Directed vectors with hand-computed expected addresses.
module tb_program_counter;
    import cpu_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  branch;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] br_address;
    logic [ADDR_WIDTH-1:0] adder_out;
    logic [ADDR_WIDTH-1:0] instr_address;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    program_counter dut (
        .clk           (clk),
        .reset         (reset),
        .branch        (branch),
        .stall         (stall),
        .adder_input   (adder_out),
        .br_address    (br_address),
        .instr_address (instr_address)
    );

    pc_adder u_pc_adder (
        .in  (instr_address),
        .out (adder_out)
    );

    // 100-unit clock period.
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        branch     = 1'b1;
        stall      = 1'b0;
        br_address = 10'h003;

        // 1. Reset overrides a pending branch, and X controls are ignored.
        tick();
        check_eq("reset_with_branch", {22'd0, instr_address}, 32'h000);
        branch = 1'bx;
        stall  = 1'bx;
        tick();
        check_eq("reset_with_x_ctrl", {22'd0, instr_address}, 32'h000);

        // 2. Release reset mid-cycle, free-run three edges.
        branch = 1'b0;
        stall  = 1'b0;
        #20;
        reset = 1'b0;
        tick();
        check_eq("run_1", {22'd0, instr_address}, 32'h001);
        tick();
        check_eq("run_2", {22'd0, instr_address}, 32'h002);
        tick();
        check_eq("run_3", {22'd0, instr_address}, 32'h003);

        // 3. Branch to 3, then free-run.
        branch     = 1'b1;
        br_address = 10'h003;
        tick();
        check_eq("branch_3", {22'd0, instr_address}, 32'h003);
        branch = 1'b0;
        tick();
        check_eq("after_br_4", {22'd0, instr_address}, 32'h004);
        tick();
        check_eq("after_br_5", {22'd0, instr_address}, 32'h005);

        // 4. Stall three edges, then branch to 2 and resume.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_hold", {22'd0, instr_address}, 32'h005);
        end
        stall      = 1'b0;
        branch     = 1'b1;
        br_address = 10'h002;
        // Inputs changed between edges must not reach the registered output.
        #10;
        check_eq("no_comb_path", {22'd0, instr_address}, 32'h005);
        tick();
        check_eq("branch_2", {22'd0, instr_address}, 32'h002);
        branch = 1'b0;
        tick();
        check_eq("after_br2_3", {22'd0, instr_address}, 32'h003);

        // 5. Branch and stall together: branch wins.
        branch     = 1'b1;
        stall      = 1'b1;
        br_address = 10'h1A5;
        tick();
        check_eq("branch_over_stall", {22'd0, instr_address}, 32'h1A5);

        // 6. Branch to the top address, wrap through zero.
        stall      = 1'b0;
        br_address = 10'h3FF;
        tick();
        check_eq("branch_3ff", {22'd0, instr_address}, 32'h3FF);
        branch = 1'b0;
        tick();
        check_eq("wrap_000", {22'd0, instr_address}, 32'h000);
        tick();
        check_eq("wrap_001", {22'd0, instr_address}, 32'h001);
        tick();
        check_eq("pre_reset_002", {22'd0, instr_address}, 32'h002);

        // Assert reset between edges: output clears without a clock edge.
        #20;
        reset = 1'b1;
        #1;
        check_eq("async_reset", {22'd0, instr_address}, 32'h000);
        tick();
        check_eq("reset_held", {22'd0, instr_address}, 32'h000);

        // Release mid-cycle; counting resumes from the reset address.
        #30;
        reset = 1'b0;
        #5;
        check_eq("released_no_edge", {22'd0, instr_address}, 32'h000);
        tick();
        check_eq("resume_001", {22'd0, instr_address}, 32'h001);
        tick();
        check_eq("resume_002", {22'd0, instr_address}, 32'h002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
